// File: rtl/onehot_sched_pkg.sv
// Shared types and helpers for the one-hot FSM engine scheduler.
// Holds the scheduler state encoding, the engine idle code and a one-hot decoder.
package onehot_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_LAUNCH   = 4'b0010,
        S_WAIT     = 4'b0100,
        S_COMPLETE = 4'b1000
    } sched_state_t;

    localparam logic [3:0] ENG_IDLE_DEF = 4'b0001;

    // Encodes a one-hot vector of up to eight bits; bits are OR-ed, so no priority logic.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_fsm_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr and wraps modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Walk the requesters from rr_ptr upward and keep the first one found.
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum_s >= (PW+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PW+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && req[idx_s]) begin
                win[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/onehot_fsm_scheduler.sv
// Shares one one-hot FSM engine among NUM_REQ requesters: round-robin grant,
// start pulse, wait for done with a watchdog, then a per-requester ack.
module onehot_fsm_scheduler
    import onehot_sched_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         TIMEOUT  = 16,
    parameter logic [3:0] ENG_IDLE = ENG_IDLE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic               eng_start,
    input  logic               eng_done,
    input  logic [3:0]         eng_state,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr,
    output logic [3:0]         sched_state
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t       state_r, state_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s, ack_r, arb_win_s;
    logic [PW-1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic [TW-1:0]      timer_r, timer_nxt_s;
    logic               arb_valid_s, set_err_s, eng_start_r, busy_r, err_r;
    logic [2:0]         win_idx_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .win    (arb_win_s),
        .valid  (arb_valid_s)
    );

    assign win_idx_s = onehot_to_idx(8'(gnt_r));

    // Next-state, grant, timer and pointer update for the transaction sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        timer_nxt_s  = timer_r;
        rr_ptr_nxt_s = rr_ptr_r;
        set_err_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A busy engine defers the launch; no grant is held meanwhile.
                if (arb_valid_s && (eng_state == ENG_IDLE)) begin
                    gnt_nxt_s   = arb_win_s;
                    state_nxt_s = S_LAUNCH;
                end else begin
                    gnt_nxt_s = '0;
                end
            end
            S_LAUNCH: begin
                timer_nxt_s = TW'(TIMEOUT);
                state_nxt_s = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_nxt_s = S_COMPLETE;
                end else if (timer_r == TW'(1)) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = S_COMPLETE;
                end else begin
                    timer_nxt_s = timer_r - TW'(1);
                end
            end
            S_COMPLETE: begin
                gnt_nxt_s = '0;
                if (win_idx_s == 3'(NUM_REQ - 1)) begin
                    rr_ptr_nxt_s = '0;
                end else begin
                    rr_ptr_nxt_s = PW'(win_idx_s + 3'd1);
                end
                state_nxt_s = S_IDLE;
            end
            default: begin
                gnt_nxt_s   = '0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            gnt_r       <= '0;
            ack_r       <= '0;
            eng_start_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            rr_ptr_r    <= '0;
            timer_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            ack_r       <= (state_nxt_s == S_COMPLETE) ? gnt_r : '0;
            eng_start_r <= (state_nxt_s == S_LAUNCH);
            busy_r      <= (state_nxt_s != S_IDLE);
            rr_ptr_r    <= rr_ptr_nxt_s;
            timer_r     <= timer_nxt_s;
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign gnt         = gnt_r;
    assign ack         = ack_r;
    assign eng_start   = eng_start_r;
    assign busy        = busy_r;
    assign timeout_err = err_r;
    assign sched_state = state_r;

endmodule

// File: tb/tb_onehot_fsm_scheduler.sv
// Directed self-checking bench for onehot_fsm_scheduler (NUM_REQ=4, TIMEOUT=16).
module tb_onehot_fsm_scheduler;

    logic       clk = 1'b0;
    logic       rst, eng_done, err_clr;
    logic [3:0] req, gnt, ack, eng_state, sched_state;
    logic       eng_start, busy, timeout_err;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_order [5];

    onehot_fsm_scheduler #(.NUM_REQ(4), .TIMEOUT(16), .ENG_IDLE(4'b0001)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .ack         (ack),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_state   (eng_state),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .sched_state (sched_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        rst = 1'b1; req = 4'b0000; eng_done = 1'b0; err_clr = 1'b0; eng_state = 4'b0001;
        step(); step();
        chk("rst_state", 32'(sched_state), 32'h1);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_start", 32'(eng_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(timeout_err), 32'h0);

        // Single request, done three cycles after start.
        rst = 1'b0; req = 4'b0010;
        step();
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_start", 32'(eng_start), 32'h1);
        chk("t1_launch", 32'(sched_state), 32'h2);
        chk("t1_busy", 32'(busy), 32'h1);
        step();
        chk("t1_start_off", 32'(eng_start), 32'h0);
        chk("t1_wait", 32'(sched_state), 32'h4);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_complete", 32'(sched_state), 32'h8);
        req = 4'b0000;
        step();
        chk("t1_ack_off", 32'(ack), 32'h0);
        chk("t1_gnt_off", 32'(gnt), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle", 32'(sched_state), 32'h1);

        // Round-robin from a freshly reset pointer with all requests held.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            req = 4'b1111;
            step();
            chk("t2_gnt", 32'(gnt), 32'(exp_order[t]));
            chk("t2_no_early_ack", 32'(ack), 32'h0);
            step();
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
            chk("t2_ack", 32'(ack), 32'(exp_order[t]));
            req = 4'b0000;
            step();
            chk("t2_ack_once", 32'(ack), 32'h0);
        end

        // Engine hang: rr_ptr is 1, so requester 0 wins after wrapping.
        req = 4'b0001;
        step();
        chk("t3_start", 32'(eng_start), 32'h1);
        chk("t3_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t3_no_err_yet", 32'(timeout_err), 32'h0);
            chk("t3_no_restart", 32'(eng_start), 32'h0);
        end
        step();
        chk("t3_err", 32'(timeout_err), 32'h1);
        chk("t3_ack", 32'(ack), 32'h1);
        chk("t3_complete", 32'(sched_state), 32'h8);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(timeout_err), 32'h0);
        chk("t3_ack_off", 32'(ack), 32'h0);

        // Reset in WAIT aborts without an ack and clears the pointer.
        req = 4'b0010;
        step();
        chk("t4_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step(); step();
        chk("t4_in_wait", 32'(sched_state), 32'h4);
        rst = 1'b1;
        step();
        chk("t4_rst_state", 32'(sched_state), 32'h1);
        chk("t4_rst_gnt", 32'(gnt), 32'h0);
        chk("t4_rst_ack", 32'(ack), 32'h0);
        chk("t4_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        chk("t4_no_ack", 32'(ack), 32'h0);
        req = 4'b1111;
        step();
        chk("t4_ptr_zero", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t4_ack", 32'(ack), 32'h1);
        step();

        // Done coincides with timer==1: done wins, no error.
        req = 4'b0001;
        step();
        chk("t5_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            step();
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t5_ack", 32'(ack), 32'h1);
        chk("t5_err", 32'(timeout_err), 32'h0);
        step();
        chk("t5_err_after", 32'(timeout_err), 32'h0);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t5_done_idle_ignored", 32'(sched_state), 32'h1);
        chk("t5_done_idle_ack", 32'(ack), 32'h0);

        // Busy engine defers the launch until it reads idle.
        eng_state = 4'b0100; req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_gnt_held", 32'(gnt), 32'h0);
            chk("t6_start_held", 32'(eng_start), 32'h0);
            chk("t6_state_idle", 32'(sched_state), 32'h1);
        end
        eng_state = 4'b0001;
        step();
        chk("t6_gnt", 32'(gnt), 32'h1);
        chk("t6_start", 32'(eng_start), 32'h1);
        req = 4'b0000;
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t6_ack", 32'(ack), 32'h1);
        step();
        chk("t6_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
